axi_line_master: RTL and testbench
==================================

// Module: axi_line_master
//
// PURPOSE
// AXI burst initiator for whole cache lines. Accepts one line-read or line-write request on a simple
// valid/ready port and runs it as a single INCR burst on axi_bus, acting as master. Returns fill data
// or a write completion. Sits between the L2 cache miss/writeback logic and the system AXI interconnect.
//
// PARAMETERS
// BURST_WORDS  16  32-bit words per line; power of 2, 2..256; burst len field = BURST_WORDS-1
// LINE_BITS    BURST_WORDS*32  derived, not overridable; width of line data ports
//
// PORTS
// clk           in   1          clock
// reset         in   1          reset, asynchronous, active-high
// axi_bus       axi_interface   master side: drives aw*/w*/ar* valids, addrs, lens, wdata, bready, rready
// req_valid     in   1          request present; hold stable until accepted
// req_ready     out  1          high only in IDLE; accept = req_valid & req_ready
// req_write     in   1          1 = line write, 0 = line read
// req_addr      in   32         byte address; low $clog2(LINE_BITS/8) bits ignored (forced 0)
// req_wdata     in   LINE_BITS  write line; word i = bits [32*i+31:32*i]
// resp_valid    out  1          one-cycle pulse: read data ready or write acknowledged
// resp_rdata    out  LINE_BITS  read line, same word order; held until next read completes
//
// BEHAVIOUR
// - States: IDLE, READ_ADDR, READ_DATA, WRITE_ADDR, WRITE_DATA, WRITE_RESP.
// - Reset (async): state=IDLE; all axi valids/readies=0; resp_valid=0; counters, line buffer, resp_rdata=0.
//   Reset mid-burst abandons the transfer with no response.
// - IDLE: req_ready=1. On accept: latch aligned address; if write, copy req_wdata into the line buffer.
//   Then go to WRITE_ADDR or READ_ADDR. beat counter=0.
// - READ_ADDR: arvalid=1, araddr=line addr, arlen=BURST_WORDS-1.
//   Hold arvalid and araddr stable until arready; then go to READ_DATA.
// - READ_DATA: rready=1. Each rvalid beat writes rdata into buffer word [beat] and increments beat.
//   On beat==BURST_WORDS-1 with rvalid: next cycle resp_valid=1, resp_rdata=buffer, state=IDLE.
// - WRITE_ADDR: awvalid=1, awaddr, awlen=BURST_WORDS-1. Hold stable until awready; then go to WRITE_DATA.
//   W beats never precede the AW handshake.
// - WRITE_DATA: wvalid=1, wdata=buffer word [beat]. Advance on wready.
//   After the last beat handshake, go to WRITE_RESP.
// - WRITE_RESP: bready=1. On bvalid: resp_valid pulse next cycle, state=IDLE.
// - rvalid/bvalid outside their states are ignored: rready/bready stay 0.
// - Min latency, zero-wait slave: read = 1 AR + BURST_WORDS beats + 1 resp cycle.
//   Write = 1 AW + BURST_WORDS beats + 1 B + 1 resp cycle.
// - Only one outstanding transaction. req_ready=0 from accept until the cycle after resp_valid.
// - beat counter is $clog2(BURST_WORDS) bits; it wraps to 0 at burst end and never overruns.
// - Address arithmetic: no 4 KB boundary check. Lines are naturally aligned, so no crossing occurs.
//
// CONFIGURATION
// AXI_LINE_MASTER_STATS_EN defined: adds output ports stat_read_lines[31:0], stat_write_lines[31:0]
//   and stat_rd_stall[31:0]. Line counters increment on each resp_valid of their type.
//   stat_rd_stall counts cycles in READ_DATA with rvalid=0. All three wrap at 2^32 and reset to 0.
// Undefined: those ports and counters do not exist; behaviour is otherwise identical.
//
// STRUCTURE
// - Package axi_line_master_pkg: line_state_t enum (six states above).
//   Also localparams WORD_BITS=32, derived beat-index width, and AXI len encoding helper.
// - Sub-module axi_line_buffer: BURST_WORDS x 32 register array.
//   Ports: parallel load from req_wdata, per-word write from rdata, per-word read for wdata, full-line read.
// - FSM, beat counter and stats counters stay in the top module.
//
// TESTING (bench: behavioural AXI slave with programmable ready/valid stalls, BURST_WORDS=16)
// - Read 0x1040, slave returns words 0xA0..0xAF zero-wait -> araddr=0x1040, arlen=15; resp_valid at cycle 18;
//   resp_rdata word0=0xA0, word15=0xAF.
// - Write 0x2000, word i = 0xC000+i -> awaddr=0x2000, awlen=15; wdata beats 0xC000..0xC00F in order;
//   resp_valid exactly once, after bvalid.
// - Slave holds arready/awready low 5 cycles and randomly deasserts wready/rvalid -> addr/valid stable;
//   no beat lost or duplicated; data intact.
// - req_addr=0x1047 -> araddr=0x1040. Stray bvalid while in IDLE -> ignored, bready=0, no resp_valid.
// - Assert reset during beat 7 of a read -> all valids 0 immediately; next request completes normally.
// - With AXI_LINE_MASTER_STATS_EN: 3 reads, 2 writes, 4 rvalid gaps -> stat_read_lines=3,
//   stat_write_lines=2, stat_rd_stall=4.

Source files
------------

// File: rtl/axi_line_master_pkg.sv
// Shared definitions for axi_line_master: FSM states, word size, AXI field widths
// and helpers for the beat-index width and the AXI burst length encoding.
package axi_line_master_pkg;

  localparam int WORD_BITS  = 32;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_LEN_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ_ADDR  = 3'd1,
    ST_READ_DATA  = 3'd2,
    ST_WRITE_ADDR = 3'd3,
    ST_WRITE_DATA = 3'd4,
    ST_WRITE_RESP = 3'd5
  } line_state_t;

  // Width of a counter that indexes every word of a line.
  function automatic int beat_idx_bits(input int burst_words);
    return (burst_words > 1) ? $clog2(burst_words) : 1;
  endfunction

  // AXI encodes a burst of N beats as N-1.
  function automatic logic [AXI_LEN_W-1:0] axi_len(input int burst_words);
    return AXI_LEN_W'(burst_words - 1);
  endfunction

endpackage

// File: rtl/axi_interface.sv
// AXI subset used by the line master: AW/W/B/AR/R handshakes with 32-bit data,
// INCR bursts only, no IDs or response codes.
interface axi_interface;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wlast;

  logic        bvalid;
  logic        bready;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    output arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    input  arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

endinterface

// File: rtl/axi_line_buffer.sv
// One cache line of storage for axi_line_master: parallel load of a write line,
// per-word fill from read beats, per-word read for write beats, full-line read.
module axi_line_buffer
  import axi_line_master_pkg::*;
#(
  parameter  int BURST_WORDS = 16,
  localparam int LINE_BITS   = BURST_WORDS * WORD_BITS,
  localparam int BEAT_W      = beat_idx_bits(BURST_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 wr_en,
  input  logic [BEAT_W-1:0]    wr_idx,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic [BEAT_W-1:0]    rd_idx,
  output logic [WORD_BITS-1:0] rd_word,
  output logic [LINE_BITS-1:0] line
);

  logic [BURST_WORDS-1:0][WORD_BITS-1:0] mem_q, mem_d;

  // Whole-line load wins over a single-word fill; the FSM never requests both.
  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_line;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_word;
    end
  end

  // Line storage register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_word = mem_q[rd_idx];
  assign line    = mem_q;

endmodule

// File: rtl/axi_line_master.sv
// AXI master that moves one whole cache line per request as a single INCR burst.
// Optional statistics counters are built when AXI_LINE_MASTER_STATS_EN is defined.
module axi_line_master
  import axi_line_master_pkg::*;
#(
  parameter  int BURST_WORDS = 16,
  localparam int LINE_BITS   = BURST_WORDS * WORD_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_interface.master          axi_bus,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [AXI_ADDR_W-1:0] req_addr,
  input  logic [LINE_BITS-1:0]  req_wdata,
  output logic                  resp_valid,
  output logic [LINE_BITS-1:0]  resp_rdata
`ifdef AXI_LINE_MASTER_STATS_EN
  ,
  output logic [31:0]           stat_read_lines,
  output logic [31:0]           stat_write_lines,
  output logic [31:0]           stat_rd_stall
`endif
);

  localparam int                    BEAT_W    = beat_idx_bits(BURST_WORDS);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_WORDS - 1);
  localparam logic [AXI_LEN_W-1:0]  BURST_LEN = axi_len(BURST_WORDS);
  localparam logic [AXI_ADDR_W-1:0] OFFS_MASK = AXI_ADDR_W'((LINE_BITS / 8) - 1);

  line_state_t           state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [LINE_BITS-1:0]  resp_rdata_q, resp_rdata_d;

  logic                  buf_load, buf_wr;
  logic [WORD_BITS-1:0]  buf_rd_word;
  logic [LINE_BITS-1:0]  buf_line;

  logic ar_valid, aw_valid, w_valid, w_last, r_ready, b_ready;

  axi_line_buffer #(.BURST_WORDS(BURST_WORDS)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load_en   (buf_load),
    .load_line (req_wdata),
    .wr_en     (buf_wr),
    .wr_idx    (beat_q),
    .wr_word   (axi_bus.rdata),
    .rd_idx    (beat_q),
    .rd_word   (buf_rd_word),
    .line      (buf_line)
  );

  // Next-state and handshake decode; AXI outputs depend on state only.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    buf_load     = 1'b0;
    buf_wr       = 1'b0;
    req_ready    = 1'b0;
    ar_valid     = 1'b0;
    aw_valid     = 1'b0;
    w_valid      = 1'b0;
    w_last       = 1'b0;
    r_ready      = 1'b0;
    b_ready      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Stay closed for the response cycle so a new request cannot overlap it.
        req_ready = !resp_valid_q;
        if (req_valid && !resp_valid_q) begin
          addr_d = req_addr & ~OFFS_MASK;
          beat_d = '0;
          if (req_write) begin
            buf_load = 1'b1;
            state_d  = ST_WRITE_ADDR;
          end else begin
            state_d  = ST_READ_ADDR;
          end
        end
      end
      ST_READ_ADDR: begin
        ar_valid = 1'b1;
        if (axi_bus.arready) state_d = ST_READ_DATA;
      end
      ST_READ_DATA: begin
        r_ready = 1'b1;
        if (axi_bus.rvalid) begin
          buf_wr = 1'b1;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            // The last word is still in flight to the buffer, so splice it in here.
            resp_valid_d = 1'b1;
            resp_rdata_d = buf_line;
            resp_rdata_d[LINE_BITS-1 -: WORD_BITS] = axi_bus.rdata;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_WRITE_ADDR: begin
        aw_valid = 1'b1;
        if (axi_bus.awready) state_d = ST_WRITE_DATA;
      end
      ST_WRITE_DATA: begin
        w_valid = 1'b1;
        w_last  = (beat_q == LAST_BEAT);
        if (axi_bus.wready) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = ST_WRITE_RESP;
        end
      end
      ST_WRITE_RESP: begin
        b_ready = 1'b1;
        if (axi_bus.bvalid) begin
          resp_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; reset abandons any burst in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign axi_bus.arvalid = ar_valid;
  assign axi_bus.araddr  = addr_q;
  assign axi_bus.arlen   = BURST_LEN;
  assign axi_bus.rready  = r_ready;
  assign axi_bus.awvalid = aw_valid;
  assign axi_bus.awaddr  = addr_q;
  assign axi_bus.awlen   = BURST_LEN;
  assign axi_bus.wvalid  = w_valid;
  assign axi_bus.wdata   = buf_rd_word;
  assign axi_bus.wlast   = w_last;
  assign axi_bus.bready  = b_ready;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

`ifdef AXI_LINE_MASTER_STATS_EN
  logic [31:0] stat_read_q, stat_read_d;
  logic [31:0] stat_write_q, stat_write_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Count finished lines (on the edge that raises resp_valid) and slave-starved read cycles.
  always_comb begin
    stat_read_d  = stat_read_q;
    stat_write_d = stat_write_q;
    stat_stall_d = stat_stall_q;
    if (state_q == ST_READ_DATA && axi_bus.rvalid && beat_q == LAST_BEAT)
      stat_read_d = stat_read_q + 32'd1;
    if (state_q == ST_WRITE_RESP && axi_bus.bvalid)
      stat_write_d = stat_write_q + 32'd1;
    if (state_q == ST_READ_DATA && !axi_bus.rvalid)
      stat_stall_d = stat_stall_q + 32'd1;
  end

  // Statistics registers, free-running and wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_read_q  <= '0;
      stat_write_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_read_q  <= stat_read_d;
      stat_write_q <= stat_write_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_read_lines  = stat_read_q;
  assign stat_write_lines = stat_write_q;
  assign stat_rd_stall    = stat_stall_q;
`endif

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: behavioural AXI slave with programmable stalls,
// directed line requests, and a response scoreboard.
module tb_axi_line_master;

  localparam int NW = 16;
  localparam int LB = NW * 32;

  typedef struct {
    logic [LB-1:0] data;
    int            lat;
  } sb_t;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_addr;
  logic [LB-1:0] req_wdata;
  logic          resp_valid;
  logic [LB-1:0] resp_rdata;
`ifdef AXI_LINE_MASTER_STATS_EN
  logic [31:0]   stat_read_lines;
  logic [31:0]   stat_write_lines;
  logic [31:0]   stat_rd_stall;
`endif

  axi_interface bus ();

  axi_line_master #(.BURST_WORDS(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .axi_bus    (bus),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata)
`ifdef AXI_LINE_MASTER_STATS_EN
    ,
    .stat_read_lines  (stat_read_lines),
    .stat_write_lines (stat_write_lines),
    .stat_rd_stall    (stat_rd_stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  sb_t         sb_q[$];
  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [LB-1:0] last_read_line = '0;

  // slave configuration and state
  int          ar_stall = 0, aw_stall = 0, b_delay = 0;
  logic [15:0] rgap_mask = '0, wgap_mask = '0;
  bit          stray = 1'b0;
  logic [31:0] rd_data [NW];
  int          rd_phase = 0, rd_beat = 0, ar_wait = 0;
  bit          r_gapped = 0, ar_seen = 0;
  logic [31:0] ar_cur = '0;
  int          wr_phase = 0, wr_beat = 0, aw_wait = 0, b_wait = 0;
  bit          w_gapped = 0, aw_seen = 0;
  logic [31:0] aw_cur = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [LB-1:0] mk_line(input logic [31:0] base, input logic [31:0] step);
    logic [LB-1:0] l;
    for (int i = 0; i < NW; i++) l[32*i +: 32] = base + 32'(i) * step;
    return l;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // read-channel slave: decisions made at negedge take effect at the next posedge
  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    forever begin
      @(negedge clk);
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      if (reset) begin
        rd_phase = 0; rd_beat = 0; ar_wait = 0; r_gapped = 0; ar_seen = 0;
      end else if (rd_phase == 0) begin
        if (stray) begin
          bus.rvalid = 1'b1;
          chk("stray_rready", 32'(bus.rready), 32'd0);
        end else if (bus.arvalid) begin
          if (!ar_seen) begin
            ar_seen = 1;
            if (ar_q.size() == 0) begin
              fail("ar_unexpected");
              ar_cur = bus.araddr;
            end else begin
              ar_cur = ar_q.pop_front();
            end
            chk("araddr", bus.araddr, ar_cur);
            chk("arlen", 32'(bus.arlen), 32'd15);
          end else begin
            chk("ar_hold", bus.araddr, ar_cur);
          end
          if (ar_wait < ar_stall) begin
            ar_wait++;
          end else begin
            bus.arready = 1'b1;
            rd_phase = 1; rd_beat = 0; ar_wait = 0; ar_seen = 0; r_gapped = 0;
          end
        end else if (ar_seen) begin
          fail("ar_dropped");
          ar_seen = 0;
        end
      end else begin
        if (rgap_mask[rd_beat] && !r_gapped) begin
          r_gapped = 1;
        end else begin
          bus.rvalid = 1'b1;
          bus.rdata  = rd_data[rd_beat];
          if (bus.rready) begin
            r_gapped = 0;
            rd_beat++;
            if (rd_beat == NW) rd_phase = 0;
          end
        end
      end
    end
  end

  // write-channel slave
  initial begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    forever begin
      @(negedge clk);
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      if (reset) begin
        wr_phase = 0; wr_beat = 0; aw_wait = 0; b_wait = 0; w_gapped = 0; aw_seen = 0;
      end else if (wr_phase == 0) begin
        if (stray) begin
          bus.bvalid = 1'b1;
          chk("stray_bready", 32'(bus.bready), 32'd0);
        end else if (bus.awvalid) begin
          chk("w_before_aw", 32'(bus.wvalid), 32'd0);
          if (!aw_seen) begin
            aw_seen = 1;
            if (aw_q.size() == 0) begin
              fail("aw_unexpected");
              aw_cur = bus.awaddr;
            end else begin
              aw_cur = aw_q.pop_front();
            end
            chk("awaddr", bus.awaddr, aw_cur);
            chk("awlen", 32'(bus.awlen), 32'd15);
          end else begin
            chk("aw_hold", bus.awaddr, aw_cur);
          end
          if (aw_wait < aw_stall) begin
            aw_wait++;
          end else begin
            bus.awready = 1'b1;
            wr_phase = 1; wr_beat = 0; aw_wait = 0; aw_seen = 0; w_gapped = 0;
          end
        end
      end else if (wr_phase == 1) begin
        if (wgap_mask[wr_beat] && !w_gapped) begin
          w_gapped = 1;
        end else begin
          bus.wready = 1'b1;
          if (bus.wvalid) begin
            w_gapped = 0;
            if (w_q.size() == 0) fail("w_unexpected");
            else chk("wdata", bus.wdata, w_q.pop_front());
            chk("wlast", 32'(bus.wlast), 32'(wr_beat == NW - 1));
            wr_beat++;
            if (wr_beat == NW) begin
              wr_phase = 2;
              b_wait = 0;
            end
          end
        end
      end else begin
        if (b_wait < b_delay) begin
          b_wait++;
        end else begin
          bus.bvalid = 1'b1;
          if (bus.bready) wr_phase = 0;
        end
      end
    end
  end

  // response monitor: pops the scoreboard on every resp_valid
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        chk("req_ready_during_resp", 32'(req_ready), 32'd0);
        if (sb_q.size() == 0) begin
          fail("resp_unexpected");
        end else begin
          e = sb_q.pop_front();
          chk_line("resp_rdata", resp_rdata, e.data);
          if (e.lat >= 0) chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] exp_addr,
                        input logic [LB-1:0] line, input int lat, input bit wait_done);
    sb_t e;
    int  n;
    e.lat = lat;
    if (wr) begin
      e.data = last_read_line;
      aw_q.push_back(exp_addr);
      for (int i = 0; i < NW; i++) w_q.push_back(line[32*i +: 32]);
    end else begin
      e.data = line;
      last_read_line = line;
      ar_q.push_back(exp_addr);
      for (int i = 0; i < NW; i++) rd_data[i] = line[32*i +: 32];
    end
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wr ? line : ~line;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = '0;
    if (wait_done) begin
      n = 0;
      while (sb_q.size() != 0 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (sb_q.size() != 0) begin
        fail("resp_timeout");
        sb_q.delete();
      end
      @(negedge clk);
      chk("req_ready_after_resp", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // reset state
    @(negedge clk);
    chk("rst_axi_valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_line("rst_resp_rdata", resp_rdata, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // zero-wait read and write
    do_req(0, 32'h0000_1040, 32'h0000_1040, mk_line(32'hA0, 32'd1), 17, 1);
    chk("rd_word0", resp_rdata[31:0], 32'hA0);
    chk("rd_word15", resp_rdata[LB-1 -: 32], 32'hAF);
    do_req(1, 32'h0000_2000, 32'h0000_2000, mk_line(32'hC000, 32'd1), 18, 1);

    // address stalls and data gaps
    ar_stall = 5; rgap_mask = 16'h8089;
    do_req(0, 32'h0000_3080, 32'h0000_3080, mk_line(32'hD000, 32'd3), -1, 1);
    aw_stall = 5; wgap_mask = 16'h0421; b_delay = 2;
    do_req(1, 32'h0000_4000, 32'h0000_4000, mk_line(32'h5555_0000, 32'h11), -1, 1);
    ar_stall = 0; rgap_mask = '0; aw_stall = 0; wgap_mask = '0; b_delay = 0;

    // stray bvalid / rvalid while idle
    stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);

    // reset during beat 7 of a read
    do_req(0, 32'h0000_8000, 32'h0000_8000, mk_line(32'hBAD0, 32'd1), -1, 0);
    n = 0;
    while (!(rd_phase == 1 && rd_beat == 7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(rd_phase == 1 && rd_beat == 7)) fail("beat7_timeout");
    #2 reset = 1'b1;
    #1;
    chk("midrst_axi_valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}, 32'd0);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk_line("midrst_resp_rdata", resp_rdata, '0);
    sb_q.delete();
    ar_q.delete();
    last_read_line = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // traffic after reset: 3 reads (one with 4 rvalid gaps), 2 writes
    do_req(0, 32'h0000_5000, 32'h0000_5000, mk_line(32'h1111_0000, 32'd1), 17, 1);
    rgap_mask = 16'h1248;
    do_req(0, 32'h0000_6040, 32'h0000_6040, mk_line(32'h2222_0000, 32'd2), -1, 1);
    rgap_mask = '0;
    do_req(1, 32'h0000_7000, 32'h0000_7000, mk_line(32'hF000, 32'd1), 18, 1);
    do_req(1, 32'h0000_7040, 32'h0000_7040, mk_line(32'hF100, 32'd1), 18, 1);
    do_req(0, 32'h0000_1047, 32'h0000_1040, mk_line(32'hE0, 32'd1), 17, 1);

`ifdef AXI_LINE_MASTER_STATS_EN
    chk("stat_read_lines", stat_read_lines, 32'd3);
    chk("stat_write_lines", stat_write_lines, 32'd2);
    chk("stat_rd_stall", stat_rd_stall, 32'd4);
`endif

    repeat (3) @(negedge clk);
    chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
    chk("w_q_drained", 32'(w_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
